seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier, the successor to the fixed unsigned shift-add unit. It adds a per-operation signed/unsigned mode, early termination when the remaining multiplier bits are zero, a zero-operand fast path and a busy flag. It keeps the load/init/done/recieved handshake, so it drops into existing datapath controllers unchanged.

---
 rtl/seq_multiplier_if.sv | 26 ++
 rtl/seq_multiplier.sv | 145 ++++++++++++++
 tb/tb_seq_multiplier.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake and operand bundle for seq_multiplier.
// The master side (datapath controller) drives the request, operands and acknowledge;
// the slave side (the multiplier) drives the status flags and the product.
interface seq_multiplier_if #(
    parameter int unsigned N = 32
);
    logic           load;
    logic           recieved;
    logic           sgn;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           init;
    logic           busy;
    logic           done;
    logic [2*N-1:0] C;

    modport master (
        output load, recieved, sgn, A, B,
        input  init, busy, done, C
    );

    modport slave (
        input  load, recieved, sgn, A, B,
        output init, busy, done, C
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with optional two's-complement mode and
// early termination once the remaining multiplier bits are all zero.
// The sign is handled by multiplying magnitudes and negating the product at the end.
module seq_multiplier #(
    parameter int unsigned N          = 32,
    parameter bit          SIGNED_EN  = 1'b1,
    parameter bit          EARLY_TERM = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    seq_multiplier_if.slave mul_if
);

    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCheck,
        StAdd,
        StShift,
        StNeg,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [2*N-1:0]   m_q, m_d;      // shifted multiplicand magnitude
    logic [N-1:0]     q_q, q_d;      // remaining multiplier magnitude bits
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             init_q, init_d;
    logic             done_q, done_d;
    logic [2*N-1:0]   c_q, c_d;

    logic             signed_op;
    logic [N-1:0]     mag_a;
    logic [N-1:0]     mag_b;

    // Operand magnitudes; -2^(N-1) wraps to itself and is then read as unsigned 2^(N-1).
    always_comb begin
        signed_op = SIGNED_EN && mul_if.sgn;
        mag_a     = (signed_op && mul_if.A[N-1]) ? -mul_if.A : mul_if.A;
        mag_b     = (signed_op && mul_if.B[N-1]) ? -mul_if.B : mul_if.B;
    end

    // Next-state and datapath update for the control sequence.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        done_d  = done_q;
        c_d     = c_q;
        // init is a single pulse covering exactly the cycle after INIT is entered
        init_d  = (state_q == StInit);

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (mul_if.load) begin
                    m_d     = {{N{1'b0}}, mag_a};
                    q_d     = mag_b;
                    neg_d   = signed_op && (mul_if.A[N-1] ^ mul_if.B[N-1]);
                    acc_d   = '0;
                    cnt_d   = CntW'(N - 1);
                    state_d = StInit;
                end
            end
            StInit: begin
                // Zero multiplier skips the loop entirely
                state_d = (EARLY_TERM && (q_q == '0)) ? StNeg : StCheck;
            end
            StCheck: begin
                state_d = q_q[0] ? StAdd : StShift;
            end
            StAdd: begin
                acc_d   = acc_q + m_q;
                state_d = StShift;
            end
            StShift: begin
                q_d   = q_q >> 1;
                m_d   = m_q << 1;
                cnt_d = cnt_q - 1'b1;
                if ((cnt_q == '0) || (EARLY_TERM && ((q_q >> 1) == '0))) begin
                    state_d = StNeg;
                end else begin
                    state_d = StCheck;
                end
            end
            StNeg: begin
                if (neg_q) begin
                    acc_d = -acc_q;
                end
                state_d = StDone;
            end
            StDone: begin
                c_d    = acc_q;
                done_d = 1'b1;
                if (mul_if.recieved) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            init_q  <= init_d;
            done_q  <= done_d;
            c_q     <= c_d;
        end
    end

    // busy is decoded straight from the state so it drops on the edge that enters DONE.
    always_comb begin
        mul_if.busy = !((state_q == StIdle) || (state_q == StDone));
        mul_if.init = init_q;
        mul_if.done = done_q;
        mul_if.C    = c_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: three N=8 instances (full featured, no early termination,
// unsigned only) driven in lockstep and compared against an arithmetic reference.
module tb_seq_multiplier;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic recieved = 1'b0;
    logic sgn = 1'b0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;

    int n_checks = 0;
    int n_errors = 0;

    bit sen_v[3] = '{1'b1, 1'b1, 1'b0};
    bit et_v[3]  = '{1'b1, 1'b0, 1'b1};

    seq_multiplier_if #(.N(N)) u_if0 ();
    seq_multiplier_if #(.N(N)) u_if1 ();
    seq_multiplier_if #(.N(N)) u_if2 ();

    assign u_if0.load = load;  assign u_if0.recieved = recieved;  assign u_if0.sgn = sgn;
    assign u_if0.A = op_a;     assign u_if0.B = op_b;
    assign u_if1.load = load;  assign u_if1.recieved = recieved;  assign u_if1.sgn = sgn;
    assign u_if1.A = op_a;     assign u_if1.B = op_b;
    assign u_if2.load = load;  assign u_if2.recieved = recieved;  assign u_if2.sgn = sgn;
    assign u_if2.A = op_a;     assign u_if2.B = op_b;

    seq_multiplier #(.N(N), .SIGNED_EN(1'b1), .EARLY_TERM(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mul_if(u_if0)
    );
    seq_multiplier #(.N(N), .SIGNED_EN(1'b1), .EARLY_TERM(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mul_if(u_if1)
    );
    seq_multiplier #(.N(N), .SIGNED_EN(1'b0), .EARLY_TERM(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mul_if(u_if2)
    );

    logic [2:0]     done_v, busy_v, init_v;
    logic [2*N-1:0] c_v [3];
    assign done_v = {u_if2.done, u_if1.done, u_if0.done};
    assign busy_v = {u_if2.busy, u_if1.busy, u_if0.busy};
    assign init_v = {u_if2.init, u_if1.init, u_if0.init};
    assign c_v[0] = u_if0.C;
    assign c_v[1] = u_if1.C;
    assign c_v[2] = u_if2.C;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact product of the operands as integers, truncated to 2N bits.
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input bit s, input bit sen);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (sen && s) begin
            if (a[N-1]) sa = sa - (1 << N);
            if (b[N-1]) sb = sb - (1 << N);
        end
        return (2*N)'(sa * sb);
    endfunction

    // Reference: cycles from accept to done = 3 + 2k + popcount(|B|).
    function automatic int ref_lat(input logic [N-1:0] b, input bit s, input bit sen,
                                   input bit et);
        int mag, k, p;
        mag = int'(b);
        if (sen && s && b[N-1]) mag = (1 << N) - mag;
        k = 0;
        p = 0;
        for (int i = 0; i < N; i++) begin
            if (mag[i]) begin
                p++;
                k = i + 1;
            end
        end
        if (!et) k = N;
        return 3 + 2 * k + p;
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                          input int hold, input bit rcv_load);
        int             lat [3];
        int             exp_lat [3];
        logic [2*N-1:0] exp_c [3];
        logic [2*N-1:0] got_c [3];
        logic [2:0]     busy_at_done;
        logic [2*N-1:0] c_hold;
        for (int i = 0; i < 3; i++) begin
            lat[i]     = -1;
            exp_lat[i] = ref_lat(b, s, sen_v[i], et_v[i]);
            exp_c[i]   = ref_prod(a, b, s, sen_v[i]);
            got_c[i]   = 'x;
        end
        busy_at_done = 'x;
        @(negedge clk);
        load = 1'b1; op_a = a; op_b = b; sgn = s;
        @(posedge clk);
        #1;
        check_eq("init_e0", 64'(u_if0.init), 64'(0));
        for (int n = 1; n <= 60 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); n++) begin
            // Scramble inputs and poke load: all of it must be ignored mid-operation
            @(negedge clk);
            load = 1'($urandom_range(0, 1));
            op_a = N'($urandom); op_b = N'($urandom); sgn = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (n == 1) begin
                check_eq("init_e1", 64'(init_v), 64'(3'b111));
                check_eq("busy_e1", 64'(busy_v), 64'(3'b111));
            end
            if (n == 2) check_eq("init_e2", 64'(init_v), 64'(0));
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && done_v[i]) begin
                    lat[i]          = n;
                    got_c[i]        = c_v[i];
                    busy_at_done[i] = busy_v[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("lat%0d a=%0h b=%0h s=%0d", i, a, b, s), 64'(lat[i]),
                     64'(exp_lat[i]));
            check_eq($sformatf("prod%0d a=%0h b=%0h s=%0d", i, a, b, s), 64'(got_c[i]),
                     64'(exp_c[i]));
        end
        check_eq("busy_at_done", 64'(busy_at_done), 64'(0));
        c_hold = c_v[1];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            load = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_eq("hold_done", 64'(done_v), 64'(3'b111));
            check_eq("hold_c", 64'(c_v[1]), 64'(c_hold));
        end
        @(negedge clk);
        recieved = 1'b1;
        load     = rcv_load;
        @(negedge clk);
        recieved = 1'b0;
        load     = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_done", 64'(done_v), 64'(0));
        check_eq("idle_busy", 64'(busy_v), 64'(0));
    endtask

    logic [N-1:0] edge_vals [5] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h01};

    initial begin
        logic [N-1:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", 64'(done_v), 64'(0));
        check_eq("rst_init", 64'(init_v), 64'(0));
        check_eq("rst_busy", 64'(busy_v), 64'(0));
        check_eq("rst_c", 64'({c_v[0], c_v[1], c_v[2]}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h03, 8'h05, 1'b0, 5, 1'b0);
        run_op(8'hFD, 8'h05, 1'b1, 0, 1'b1);
        run_op(8'h80, 8'h80, 1'b1, 1, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0, 0, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0, 2, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b1);

        // Abort an operation in flight; everything must clear at once
        @(negedge clk);
        load = 1'b1; op_a = 8'h37; op_b = 8'hB5; sgn = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_done", 64'(done_v), 64'(0));
        check_eq("abort_init", 64'(init_v), 64'(0));
        check_eq("abort_busy", 64'(busy_v), 64'(0));
        check_eq("abort_c", 64'({c_v[0], c_v[1], c_v[2]}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h37, 8'hB5, 1'b1, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
